// File: rtl/mmio_timer_responder.sv
// rtl/mmio_timer_responder.sv - memory-mapped prescaled 32-bit timer with compare match and interrupt
// Optional interrupt output enabled by defining TIMER_IRQ_EN.
module mmio_timer_responder #(
    parameter logic [31:0] BASE_ADDR = 32'h0000_8000,
    parameter int          WIN_BITS  = 4
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        MemWrite,
    input  logic [31:0] DataAdr,
    input  logic [31:0] WriteData,
    output logic [31:0] ReadData,
    output logic        Sel,
    output logic        IRQ
);

    localparam int OW = WIN_BITS - 2;

    localparam logic [OW-1:0] OFF_CTRL    = OW'(0);
    localparam logic [OW-1:0] OFF_COUNT   = OW'(1);
    localparam logic [OW-1:0] OFF_COMPARE = OW'(2);
    localparam logic [OW-1:0] OFF_STATUS  = OW'(3);

    logic          ctrlEn;
    logic          ctrlAutoReload;
    logic          ctrlIrqEnBit;
    logic [7:0]    ctrlPrescale;
    logic [7:0]    prescaler;
    logic [31:0]   count;
    logic [31:0]   compare;
    logic          match;

    logic [OW-1:0] regOffset;
    logic [1:0]    unusedAdrBits;
    logic          busWrite;
    logic          wrCtrl;
    logic          wrCount;
    logic          wrCompare;
    logic          wrStatus;
    logic          tick;
    logic          countHit;
    logic          matchSet;
    logic [31:0]   ctrlRead;

    assign Sel           = (DataAdr[31:WIN_BITS] == BASE_ADDR[31:WIN_BITS]);
    assign regOffset     = DataAdr[WIN_BITS-1:2];
    assign unusedAdrBits = DataAdr[1:0];

    assign busWrite  = MemWrite && Sel;
    assign wrCtrl    = busWrite && (regOffset == OFF_CTRL);
    assign wrCount   = busWrite && (regOffset == OFF_COUNT);
    assign wrCompare = busWrite && (regOffset == OFF_COMPARE);
    assign wrStatus  = busWrite && (regOffset == OFF_STATUS);

    // Tick, match and the increment all use pre-edge register values, so a
    // same-cycle CTRL or COMPARE write cannot alter the tick being taken.
    assign tick     = ctrlEn && (prescaler == ctrlPrescale);
    assign countHit = (count == compare);
    assign matchSet = tick && countHit;

    assign ctrlRead = {16'h0000, ctrlPrescale, 5'b00000, ctrlIrqEnBit, ctrlAutoReload, ctrlEn};

    always_comb begin
        ReadData = 32'h0000_0000;
        if (Sel) begin
            case (regOffset)
                OFF_CTRL:    ReadData = ctrlRead;
                OFF_COUNT:   ReadData = count;
                OFF_COMPARE: ReadData = compare;
                OFF_STATUS:  ReadData = {31'h0000_0000, match};
                default:     ReadData = 32'h0000_0000;
            endcase
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            ctrlEn         <= 1'b0;
            ctrlAutoReload <= 1'b0;
            ctrlPrescale   <= 8'h00;
            prescaler      <= 8'h00;
            count          <= 32'h0000_0000;
            compare        <= 32'hFFFF_FFFF;
            match          <= 1'b0;
        end else begin
            if (wrCtrl) begin
                ctrlEn         <= WriteData[0];
                ctrlAutoReload <= WriteData[1];
                ctrlPrescale   <= WriteData[15:8];
            end

            // Prescaler freezes (not clears) while disabled.
            if (ctrlEn) begin
                prescaler <= tick ? 8'h00 : prescaler + 8'h01;
            end

            // A CPU store to COUNT overrides the increment of the same cycle.
            if (wrCount) begin
                count <= WriteData;
            end else if (tick) begin
                count <= (countHit && ctrlAutoReload) ? 32'h0000_0000 : count + 32'h0000_0001;
            end

            if (wrCompare) begin
                compare <= WriteData;
            end

            // Hardware set has priority over a simultaneous write-1-to-clear.
            if (matchSet) begin
                match <= 1'b1;
            end else if (wrStatus && WriteData[0]) begin
                match <= 1'b0;
            end
        end
    end

`ifdef TIMER_IRQ_EN
    logic ctrlIrqEn;
    logic irqReg;

    assign ctrlIrqEnBit = ctrlIrqEn;
    assign IRQ          = irqReg;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            ctrlIrqEn <= 1'b0;
            irqReg    <= 1'b0;
        end else begin
            if (wrCtrl) begin
                ctrlIrqEn <= WriteData[2];
            end
            irqReg <= match && ctrlIrqEn;
        end
    end
`else
    assign ctrlIrqEnBit = 1'b0;
    assign IRQ          = 1'b0;
`endif

endmodule
